mc_controller: RTL and testbench

Multicycle control unit for the MIPS core. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback states, one state per clock. It generates every datapath enable and mux select, and stalls on a memory-ready handshake. It replaces the purely combinational control path when the core runs in multicycle mode, and drives the same ALU control encoding.

---
 rtl/mips_defs.sv | 46 ++++
 rtl/alu_decoder.sv | 31 +++
 rtl/mc_controller.sv | 154 +++++++++++++++
 tb/tb_mc_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, functs, ALU op/control codes and
// the multicycle controller state encodings.
package mips_defs;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // Aluop codes from the main controller
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Alucontrol codes into the ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Multicycle controller states
  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BEQ    = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the controller Aluop and the R-type funct field onto
// the 3-bit ALU control code.
module alu_decoder
  import mips_defs::*;
(
  input  logic [5:0] funct,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  // Aluop selects add/sub directly or defers to funct for R-type
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: one state per clock through fetch, decode,
// execute, memory and writeback, stalling on the memory-ready handshake.
module mc_controller
  import mips_defs::*;
#(
  parameter logic [3:0] RESET_STATE = FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       irwrite,
  output logic       mem_req,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] Alucontrol,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  logic [3:0] state, state_next;
  logic [1:0] aluop;
  logic       op_legal;
  logic       pc_en_raw, irwrite_raw, mem_req_raw, memwrite_raw, regwrite_raw;

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_next;
  end

  // Opcode legality check used by DECODE
  always_comb begin
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                      op_legal = 1'b0;
    endcase
  end

  // Next-state logic; mem_ready only matters in states that request memory
  always_comb begin
    state_next = state;
    case (state)
      FETCH:  if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (op)
          OP_RTYPE:     state_next = EXEC;
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BEQ;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR: state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) state_next = MEMWB;
      MEMWR:  if (mem_ready) state_next = FETCH;
      EXEC:   state_next = ALUWB;
      ADDIEX: state_next = ADDIWB;
      MEMWB, ALUWB, BEQ, ADDIWB, JUMP: state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Moore output decode, with pc_en gated by zero and fetch strobes by mem_ready
  always_comb begin
    pc_en_raw    = 1'b0;
    iord         = 1'b0;
    irwrite_raw  = 1'b0;
    mem_req_raw  = 1'b0;
    memwrite_raw = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    regwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;
    illegal_op   = 1'b0;
    case (state)
      FETCH: begin
        mem_req_raw = 1'b1;
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pc_en_raw   = mem_ready;
      end
      DECODE: begin
        alusrcb    = 2'b11;
        illegal_op = ~op_legal;
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        mem_req_raw = 1'b1;
        iord        = 1'b1;
      end
      MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      MEMWR: begin
        mem_req_raw  = 1'b1;
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      BEQ: begin
        alusrca   = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc     = 2'b01;
        pc_en_raw = zero;
      end
      ADDIWB: regwrite_raw = 1'b1;
      JUMP: begin
        pcsrc     = 2'b10;
        pc_en_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are forced low for as long as reset is held, not just at the edge
  assign pc_en    = rst_n & pc_en_raw;
  assign irwrite  = rst_n & irwrite_raw;
  assign mem_req  = rst_n & mem_req_raw;
  assign memwrite = rst_n & memwrite_raw;
  assign regwrite = rst_n & regwrite_raw;
  assign state_o  = state;

  alu_decoder u_alu_decoder (
    .funct      (funct),
    .aluop      (aluop),
    .alucontrol (Alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: each task walks one instruction cycle by
// cycle and compares the state and the full control word against hand tables.
module tb_mc_controller;
  import mips_defs::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, irwrite, mem_req, memwrite, memtoreg, regdst, regwrite;
  logic       alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] Alucontrol;
  logic [3:0] state_o;
  logic [16:0] ctrl;

  int passed = 0;
  int total = 0;

  // Control word: {pc_en,iord,irwrite,mem_req,memwrite,memtoreg,regdst,regwrite,alusrca}
  //               _alusrcb_pcsrc_Alucontrol_illegal_op
  localparam logic [16:0] W_RST   = 17'b000000000_01_00_010_0;
  localparam logic [16:0] W_FRDY  = 17'b101100000_01_00_010_0;
  localparam logic [16:0] W_FWAIT = 17'b000100000_01_00_010_0;
  localparam logic [16:0] W_DEC   = 17'b000000000_11_00_010_0;
  localparam logic [16:0] W_DECIL = 17'b000000000_11_00_010_1;
  localparam logic [16:0] W_MADR  = 17'b000000001_10_00_010_0;
  localparam logic [16:0] W_MRD   = 17'b010100000_00_00_010_0;
  localparam logic [16:0] W_MWB   = 17'b000001010_00_00_010_0;
  localparam logic [16:0] W_MWR   = 17'b010110000_00_00_010_0;
  localparam logic [16:0] W_EXSUB = 17'b000000001_00_00_110_0;
  localparam logic [16:0] W_ALUWB = 17'b000000110_00_00_010_0;
  localparam logic [16:0] W_BEQT  = 17'b100000001_00_01_110_0;
  localparam logic [16:0] W_BEQN  = 17'b000000001_00_01_110_0;
  localparam logic [16:0] W_ADDEX = 17'b000000001_10_00_010_0;
  localparam logic [16:0] W_ADDWB = 17'b000000010_00_00_010_0;
  localparam logic [16:0] W_JUMP  = 17'b100000000_00_10_010_0;

  assign ctrl = {pc_en, iord, irwrite, mem_req, memwrite, memtoreg, regdst, regwrite,
                 alusrca, alusrcb, pcsrc, Alucontrol, illegal_op};

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .irwrite    (irwrite),
    .mem_req    (mem_req),
    .memwrite   (memwrite),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .Alucontrol (Alucontrol),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #2;
    total++;
    if (state_o !== FETCH) $display("FAIL reset_state: got %0d want %0d", state_o, FETCH);
    else passed++;
    total++;
    if (ctrl !== W_RST) $display("FAIL reset_ctrl: got %b want %b", ctrl, W_RST);
    else passed++;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    logic [3:0]  st [0:5];
    logic [16:0] cw [0:5];
    logic        rdy [0:5];
    st  = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH};
    cw  = '{W_FRDY, W_DEC, W_MADR, W_MRD, W_MWB, W_FWAIT};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = OP_LW;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      #1;
      total++;
      if (state_o !== st[c]) $display("FAIL lw_state c%0d: got %0d want %0d", c, state_o, st[c]);
      else passed++;
      total++;
      if (ctrl !== cw[c]) $display("FAIL lw_ctrl c%0d: got %b want %b", c, ctrl, cw[c]);
      else passed++;
    end
  endtask

  task automatic test_rtype_sub();
    logic [3:0]  st [0:4];
    logic [16:0] cw [0:4];
    logic        rdy [0:4];
    st  = '{FETCH, DECODE, EXEC, ALUWB, FETCH};
    cw  = '{W_FRDY, W_DEC, W_EXSUB, W_ALUWB, W_FWAIT};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = OP_RTYPE;
    funct = F_SUB;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      #1;
      total++;
      if (state_o !== st[c]) $display("FAIL rsub_state c%0d: got %0d want %0d", c, state_o, st[c]);
      else passed++;
      total++;
      if (ctrl !== cw[c]) $display("FAIL rsub_ctrl c%0d: got %b want %b", c, ctrl, cw[c]);
      else passed++;
    end
  endtask

  task automatic test_rtype_functs();
    logic [5:0] fn  [0:5];
    logic [2:0] alu [0:5];
    fn  = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, 6'b111111};
    alu = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    op = OP_RTYPE;
    for (int i = 0; i < 6; i++) begin
      funct = fn[i];
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        mem_ready = (c < 4);
        #1;
        if (c == 2) begin
          total++;
          if (state_o !== EXEC || Alucontrol !== alu[i])
            $display("FAIL funct_%b: got state %0d alu %b want state %0d alu %b",
                     fn[i], state_o, Alucontrol, EXEC, alu[i]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0]  st [0:3];
    logic [16:0] cw [0:3];
    logic        rdy [0:3];
    st  = '{FETCH, DECODE, BEQ, FETCH};
    cw  = '{W_FRDY, W_DEC, (z ? W_BEQT : W_BEQN), W_FWAIT};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0};
    op = OP_BEQ;
    zero = z;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      #1;
      total++;
      if (state_o !== st[c]) $display("FAIL beq%0d_state c%0d: got %0d want %0d", z, c, state_o, st[c]);
      else passed++;
      total++;
      if (ctrl !== cw[c]) $display("FAIL beq%0d_ctrl c%0d: got %b want %b", z, c, ctrl, cw[c]);
      else passed++;
    end
    zero = 1'b0;
  endtask

  task automatic test_addi();
    logic [3:0]  st [0:4];
    logic [16:0] cw [0:4];
    logic        rdy [0:4];
    st  = '{FETCH, DECODE, ADDIEX, ADDIWB, FETCH};
    cw  = '{W_FRDY, W_DEC, W_ADDEX, W_ADDWB, W_FWAIT};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = OP_ADDI;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      #1;
      total++;
      if (state_o !== st[c]) $display("FAIL addi_state c%0d: got %0d want %0d", c, state_o, st[c]);
      else passed++;
      total++;
      if (ctrl !== cw[c]) $display("FAIL addi_ctrl c%0d: got %b want %b", c, ctrl, cw[c]);
      else passed++;
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0]  st [0:7];
    logic [16:0] cw [0:7];
    logic        rdy [0:7];
    int          mw_cycles;
    st  = '{FETCH, DECODE, MEMADR, MEMWR, MEMWR, MEMWR, MEMWR, FETCH};
    cw  = '{W_FRDY, W_DEC, W_MADR, W_MWR, W_MWR, W_MWR, W_MWR, W_FWAIT};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mw_cycles = 0;
    op = OP_SW;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      #1;
      if (memwrite === 1'b1) mw_cycles++;
      total++;
      if (state_o !== st[c]) $display("FAIL sw_state c%0d: got %0d want %0d", c, state_o, st[c]);
      else passed++;
      total++;
      if (ctrl !== cw[c]) $display("FAIL sw_ctrl c%0d: got %b want %b", c, ctrl, cw[c]);
      else passed++;
    end
    total++;
    if (mw_cycles !== 4) $display("FAIL sw_memwrite_len: got %0d want 4", mw_cycles);
    else passed++;
  endtask

  task automatic test_fetch_stall_jump();
    logic [3:0]  st [0:5];
    logic [16:0] cw [0:5];
    logic        rdy [0:5];
    st  = '{FETCH, FETCH, FETCH, DECODE, JUMP, FETCH};
    cw  = '{W_FWAIT, W_FWAIT, W_FRDY, W_DEC, W_JUMP, W_FWAIT};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    op = OP_J;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      #1;
      total++;
      if (state_o !== st[c]) $display("FAIL j_state c%0d: got %0d want %0d", c, state_o, st[c]);
      else passed++;
      total++;
      if (ctrl !== cw[c]) $display("FAIL j_ctrl c%0d: got %b want %b", c, ctrl, cw[c]);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [0:2];
    logic [16:0] cw [0:2];
    logic        rdy [0:2];
    st  = '{FETCH, DECODE, FETCH};
    cw  = '{W_FRDY, W_DECIL, W_FWAIT};
    rdy = '{1'b1, 1'b1, 1'b0};
    op = 6'b111111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      #1;
      total++;
      if (state_o !== st[c]) $display("FAIL ill_state c%0d: got %0d want %0d", c, state_o, st[c]);
      else passed++;
      total++;
      if (ctrl !== cw[c]) $display("FAIL ill_ctrl c%0d: got %b want %b", c, ctrl, cw[c]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  st [0:4];
    logic        rdy [0:4];
    op = OP_LW;
    st  = '{FETCH, DECODE, MEMADR, MEMRD, MEMRD};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      #1;
      total++;
      if (state_o !== st[c]) $display("FAIL rmid_pre c%0d: got %0d want %0d", c, state_o, st[c]);
      else passed++;
    end
    // Assert reset well away from any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (state_o !== FETCH) $display("FAIL rmid_async_state: got %0d want %0d", state_o, FETCH);
    else passed++;
    mem_ready = 1'b1;
    #1;
    total++;
    if (ctrl !== W_RST) $display("FAIL rmid_hold_ctrl: got %b want %b", ctrl, W_RST);
    else passed++;
    @(negedge clk);
    total++;
    if (state_o !== FETCH || ctrl !== W_RST)
      $display("FAIL rmid_after_edge: got state %0d ctrl %b want %0d %b",
               state_o, ctrl, FETCH, W_RST);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++;
    if (ctrl !== W_FRDY) $display("FAIL rmid_release_ctrl: got %b want %b", ctrl, W_FRDY);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (state_o !== DECODE) $display("FAIL rmid_first_fetch: got %0d want %0d", state_o, DECODE);
    else passed++;
    st  = '{DECODE, MEMADR, MEMRD, MEMWB, FETCH};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ready = rdy[c];
      #1;
      total++;
      if (state_o !== st[c]) $display("FAIL rmid_post c%0d: got %0d want %0d", c, state_o, st[c]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_sub();
    test_rtype_functs();
    test_beq(1'b1);
    test_beq(1'b0);
    test_addi();
    test_sw_wait();
    test_fetch_stall_jump();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
